// File: rtl/isi_pattern_monitor_pkg.sv
// Shared constants and state type for the ISI pattern generator/monitor pair.
// LANES and PATTERNS must stay in step with the generator side.
package isi_pkg;

  localparam int LANES    = 5;
  localparam int PATTERNS = 1 << LANES;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    TIMEOUT
  } isi_mon_state_t;

endpackage

// File: rtl/isi_pattern_monitor_lane_run_counter.sv
// Per-lane run-length tracker: remembers the previous bit and counts identical repeats.
// run_len shows the length including bit_in while step is high, so the top can reduce it on the same edge.
module lane_run_counter #(
  parameter int RUN_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             step,
  input  logic             bit_in,
  input  logic             first,
  output logic [RUN_W-1:0] run_len
);

  localparam logic [RUN_W-1:0] RUN_MAX = '1;
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  logic             prev_bit;
  logic [RUN_W-1:0] run_q;

  always_comb begin
    run_len = run_q;
    if (step) begin
      if (first || (bit_in != prev_bit)) begin
        run_len = RUN_ONE;
      end else if (run_q != RUN_MAX) begin
        run_len = run_q + RUN_ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_bit <= 1'b0;
      run_q    <= '0;
    end else if (clr) begin
      prev_bit <= 1'b0;
      run_q    <= '0;
    end else if (step) begin
      prev_bit <= bit_in;
      run_q    <= run_len;
    end
  end

endmodule

// File: rtl/isi_pattern_monitor.sv
// Scores an ISI lane generator: pattern coverage, sample count to full coverage,
// and the longest constant run seen on any lane.
module isi_pattern_monitor
  import isi_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 1000,
  parameter int RUN_W      = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                start,
  input  logic [LANES-1:0]    lin,
  output logic [PATTERNS-1:0] seen_map,
  output logic [LANES:0]      unique_count,
  output logic [CNT_W-1:0]    cycle_count,
  output logic [RUN_W-1:0]    max_run,
  output logic                busy,
  output logic                done,
  output logic                timeout
);

  isi_mon_state_t state, state_next;

  logic             accept;
  logic             first_sample;
  logic             new_pattern;
  logic [LANES:0]   uniq_next;
  logic [CNT_W-1:0] cnt_next;
  logic [RUN_W-1:0] max_next;
  logic [RUN_W-1:0] run_len [LANES];

  // The lin value on a start cycle is never recorded, hence !start.
  assign accept       = (state == RUN) && enable && !start;
  assign first_sample = (cycle_count == '0);
  assign new_pattern  = !seen_map[lin];
  assign uniq_next    = unique_count + {{LANES{1'b0}}, new_pattern};
  assign cnt_next     = cycle_count + CNT_W'(1);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_run_counter #(.RUN_W(RUN_W)) u_lane (
      .clock   (clock),
      .reset   (reset),
      .clr     (start),
      .step    (accept),
      .bit_in  (lin[i]),
      .first   (first_sample),
      .run_len (run_len[i])
    );
  end

  always_comb begin
    max_next = max_run;
    for (int i = 0; i < LANES; i++) begin
      if (run_len[i] > max_next) max_next = run_len[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Completion is tested before the budget so that a coverage-completing last sample wins.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = RUN;
    end else if (accept) begin
      if (uniq_next == (LANES+1)'(PATTERNS))    state_next = DONE;
      else if (cnt_next == CNT_W'(MAX_CYCLES))  state_next = TIMEOUT;
    end
  end

  always_comb begin
    busy    = (state == RUN);
    done    = (state == DONE);
    timeout = (state == TIMEOUT);
  end

  always_ff @(posedge clock) begin
    if (!reset || start) begin
      seen_map     <= '0;
      unique_count <= '0;
      cycle_count  <= '0;
      max_run      <= '0;
    end else if (accept) begin
      seen_map[lin] <= 1'b1;
      unique_count  <= uniq_next;
      cycle_count   <= cnt_next;
      max_run       <= max_next;
    end
  end

endmodule

// File: tb/tb_isi_pattern_monitor.sv
// Self-checking bench for isi_pattern_monitor: directed scenarios plus randomized
// measurements compared every cycle against an array-based reference model.
module tb_isi_pattern_monitor;
  import isi_pkg::*;

  localparam int CNT_W      = 16;
  localparam int MAX_CYCLES = 1000;
  localparam int RUN_W      = 8;
  localparam int RUN_SAT    = (1 << RUN_W) - 1;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_TIMEOUT = 3;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                enable = 1'b0;
  logic                start = 1'b0;
  logic [LANES-1:0]    lin = '0;
  logic [PATTERNS-1:0] seen_map;
  logic [LANES:0]      unique_count;
  logic [CNT_W-1:0]    cycle_count;
  logic [RUN_W-1:0]    max_run;
  logic                busy, done, timeout;

  int n_compared   = 0;
  int n_mismatched = 0;

  bit m_seen [PATTERNS];
  bit m_prev [LANES];
  int m_run  [LANES];
  int m_cnt, m_max, m_state;

  isi_pattern_monitor #(.CNT_W(CNT_W), .MAX_CYCLES(MAX_CYCLES), .RUN_W(RUN_W)) dut (
    .clock(clock), .reset(reset), .enable(enable), .start(start), .lin(lin),
    .seen_map(seen_map), .unique_count(unique_count), .cycle_count(cycle_count),
    .max_run(max_run), .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic int modelUnique();
    int n = 0;
    for (int p = 0; p < PATTERNS; p++) n += int'(m_seen[p]);
    return n;
  endfunction

  task automatic modelClear();
    for (int p = 0; p < PATTERNS; p++) m_seen[p] = 1'b0;
    for (int i = 0; i < LANES; i++) begin m_prev[i] = 1'b0; m_run[i] = 0; end
    m_cnt = 0;
    m_max = 0;
  endtask

  // Reference behaviour: one call per rising edge with the inputs sampled there.
  task automatic modelStep(input bit rst, input bit st, input bit en, input logic [LANES-1:0] l);
    if (!rst) begin
      m_state = M_IDLE;
      modelClear();
    end else if (st) begin
      m_state = M_RUN;
      modelClear();
    end else if (m_state == M_RUN && en) begin
      m_seen[l] = 1'b1;
      for (int i = 0; i < LANES; i++) begin
        if (m_cnt == 0 || l[i] != m_prev[i]) m_run[i] = 1;
        else if (m_run[i] < RUN_SAT)         m_run[i] = m_run[i] + 1;
        m_prev[i] = l[i];
        if (m_run[i] > m_max) m_max = m_run[i];
      end
      m_cnt++;
      if (modelUnique() == PATTERNS) m_state = M_DONE;
      else if (m_cnt == MAX_CYCLES)  m_state = M_TIMEOUT;
    end
  endtask

  task automatic checkAll();
    logic [PATTERNS-1:0] exp_map;
    for (int p = 0; p < PATTERNS; p++) exp_map[p] = m_seen[p];
    checkOutput("seen_map", 64'(seen_map), 64'(exp_map));
    checkOutput("unique_count", 64'(unique_count), 64'(modelUnique()));
    checkOutput("cycle_count", 64'(cycle_count), 64'(m_cnt));
    checkOutput("max_run", 64'(max_run), 64'(m_max));
    checkOutput("busy", 64'(busy), 64'(m_state == M_RUN));
    checkOutput("done", 64'(done), 64'(m_state == M_DONE));
    checkOutput("timeout", 64'(timeout), 64'(m_state == M_TIMEOUT));
  endtask

  task automatic applyStimulus(input bit rst, input bit st, input bit en, input logic [LANES-1:0] l);
    reset  = rst;
    start  = st;
    enable = en;
    lin    = l;
    @(posedge clock);
    modelStep(rst, st, en, l);
    #1;
    checkAll();
  endtask

  task automatic runSweep(input bit gaps);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    for (int v = 0; v < PATTERNS; v++) begin
      if (gaps) applyStimulus(1'b1, 1'b0, 1'b0, LANES'($urandom));
      applyStimulus(1'b1, 1'b0, 1'b1, LANES'(v));
    end
  endtask

  initial begin
    logic [LANES-1:0] mask;
    m_state = M_IDLE;
    modelClear();

    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 1'b1, '1);
    checkOutput("reset_busy", 64'(busy), 64'd0);

    // Full sweep 0..31: lane 4 holds 16 cycles.
    runSweep(1'b0);
    checkOutput("sweep_done", 64'(done), 64'd1);
    checkOutput("sweep_unique", 64'(unique_count), 64'd32);
    checkOutput("sweep_cycles", 64'(cycle_count), 64'd32);
    checkOutput("sweep_max_run", 64'(max_run), 64'd16);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd3);
    checkOutput("done_holds", 64'(cycle_count), 64'd32);

    // Constant pattern until the sample budget runs out.
    applyStimulus(1'b1, 1'b1, 1'b1, 5'b10101);
    for (int k = 0; k < MAX_CYCLES; k++) applyStimulus(1'b1, 1'b0, 1'b1, 5'b10101);
    checkOutput("const_timeout", 64'(timeout), 64'd1);
    checkOutput("const_unique", 64'(unique_count), 64'd1);
    checkOutput("const_map", 64'(seen_map), 64'h0020_0000);
    checkOutput("const_max_run", 64'(max_run), 64'd255);
    checkOutput("const_cycles", 64'(cycle_count), 64'd1000);

    // Duplicates of 7 must not advance coverage.
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    for (int v = 0; v < 31; v++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, LANES'(v));
      if (v == 7) begin
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd7);
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd7);
      end
    end
    checkOutput("dup_not_done", 64'(done), 64'd0);
    checkOutput("dup_unique", 64'(unique_count), 64'd31);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd31);
    checkOutput("dup_done", 64'(done), 64'd1);
    checkOutput("dup_cycles", 64'(cycle_count), 64'd34);

    // Enable gaps are transparent.
    runSweep(1'b1);
    checkOutput("gap_done", 64'(done), 64'd1);
    checkOutput("gap_max_run", 64'(max_run), 64'd16);

    // Restart mid-measurement, including back-to-back starts.
    applyStimulus(1'b1, 1'b1, 1'b1, '0);
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b0, 1'b1, LANES'($urandom));
    applyStimulus(1'b1, 1'b1, 1'b1, '0);
    runSweep(1'b0);
    checkOutput("restart_cycles", 64'(cycle_count), 64'd32);

    // Reset mid-run discards everything and leaves the monitor idle.
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    for (int k = 0; k < 20; k++) applyStimulus(1'b1, 1'b0, 1'b1, LANES'($urandom));
    applyStimulus(1'b0, 1'b0, 1'b1, '1);
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, 1'b0, 1'b1, LANES'(k[0] ? 31 : 0));
    checkOutput("post_reset_cycles", 64'(cycle_count), 64'd0);
    checkOutput("post_reset_done", 64'(done), 64'd0);

    // Randomized measurements; narrowed lane masks make timeouts reachable.
    for (int r = 0; r < 12; r++) begin
      mask = (r % 3 == 2) ? LANES'($urandom | 1) : '1;
      applyStimulus(1'b1, 1'b1, 1'($urandom), LANES'($urandom));
      for (int k = 0; k < 1100 && m_state == M_RUN; k++) begin
        applyStimulus(($urandom_range(0, 499) != 0), ($urandom_range(0, 399) == 0),
                      ($urandom_range(0, 3) != 0), LANES'($urandom) & mask);
      end
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b1, LANES'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/isi_pattern_monitor.md
# isi_pattern_monitor

Downstream consumer of the multi-lane LFSR ISI signal generator. Each enabled cycle it samples the LANES-bit lane vector and records which of the 2^LANES lane patterns have occurred. It counts samples until every pattern is covered, and tracks the longest constant run on any single lane. It reports coverage-complete or timeout so the pattern generator's seeds and lane delays can be scored.

## Interface
- LANES, 5, lane count; the pattern space is PATTERNS = 2^LANES.
- CNT_W, 16, width of the sample counter.
- MAX_CYCLES, 1000, accepted-sample budget before timeout; must be < 2^CNT_W.
- RUN_W, 8, width of the run-length counters; these saturate at 2^RUN_W-1.
- clock  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  sample qualifier; must be the same enable that drives the generator.
- start  input  1  single-cycle pulse that clears statistics and begins a measurement.
- lin  input  LANES  lane vector from the generator.
- seen_map  output  PATTERNS  bit p set = pattern p observed.
- unique_count  output  LANES+1  number of set bits in seen_map.
- cycle_count  output  CNT_W  accepted samples since start.
- max_run  output  RUN_W  longest consecutive identical-value run on any lane.
- busy  output  1  state == RUN.
- done  output  1  state == DONE (full coverage).
- timeout  output  1  state == TIMEOUT.

## Operation
- States: IDLE, RUN, DONE, TIMEOUT. All outputs are registered or decoded from state.
- Reset (reset==0 at an edge): state goes to IDLE and every output clears to 0. Reset has priority over every other input.
- start==1, from any state: seen_map, unique_count, cycle_count, max_run and the per-lane run counters all clear; state goes to RUN. The lin value on the start cycle is not recorded.
- Accepted sample: state==RUN, enable==1, start==0. On such an edge:
  - seen_map[lin] is set.
  - unique_count increments only if that bit was previously 0.
  - cycle_count increments.
  - Each lane's run counter updates (see below).
- Lane run counters: for each lane i, if this is the first sample after start, run_len[i]=1. Otherwise run_len[i] increments (saturating) when lin[i] equals the previous sample of lane i, else it resets to 1. The previous sample is updated on every accepted sample.
- max_run takes the maximum of itself and every updated run_len[i] on the same edge.
- Completion: on the edge where unique_count becomes PATTERNS, the state goes to DONE.
- Timeout: on the edge where cycle_count becomes MAX_CYCLES with unique_count < PATTERNS, the state goes to TIMEOUT.
- If both happen on the same edge, DONE wins.
- In DONE, TIMEOUT and IDLE, all statistics hold and lin and enable are ignored.
- enable==0 while in RUN: nothing changes, and run counters do not advance (gaps are transparent).

## Timing
- Latency is one edge. An accepted sample at edge k is visible on every output after edge k.
- done and timeout are levels, not pulses. They hold until start or reset.
- busy rises on the edge after start is sampled. start in the cycle immediately after that is legal and restarts again.
- unique_count never exceeds PATTERNS, and cycle_count never exceeds MAX_CYCLES.
- Because max_run saturates at 2^RUN_W-1, it never wraps.
- Reset in mid-RUN discards all statistics with no completion flag.

## Structure
- Package isi_pkg holds:
  - LANES and PATTERNS constants, shared with the generator side.
  - The state typedef isi_mon_state_t {IDLE, RUN, DONE, TIMEOUT}.
- Sub-module lane_run_counter, instantiated LANES times:
  - Inputs: clock, reset, clr, step, bit_in, first.
  - Output: run_len.
  - Contains the previous-bit register and the saturating counter.
- The top level contains the FSM, seen_map, the population counter, cycle_count and the max_run reduction.

## Test plan
- Reset, start, then lin = 0,1,…,31 on 32 consecutive enabled cycles → done=1 after the 32nd edge; unique_count=32, cycle_count=32, max_run=16 (lane 4 is held 16 cycles).
- start, then lin fixed at 5'b10101 for 1000 enabled cycles → timeout=1 at cycle 1000; unique_count=1, seen_map only bit 21 set, max_run=255 (saturated).
- start, then 0..30 with repeats of 7 inserted, then 31 → duplicates do not raise unique_count; done only on the 31 sample; cycle_count equals the total samples.
- Same as the first scenario but with enable low every other cycle → identical final results; gaps do not change max_run.
- start, 10 samples, then start again, then 0..31 → the first 10 samples are discarded; cycle_count=32 at done.
- start, 20 samples, then reset low for 1 cycle → all outputs 0, state IDLE; subsequent lin toggling records nothing until start.
